// File: rtl/vga_cfg_pkg.sv
// Shared constants, commit-state type and byte-lane merge helper for the VGA config controller.
package vga_cfg_pkg;
  localparam logic [2:0] OFS_CTRL     = 3'h0;
  localparam logic [2:0] OFS_STATUS   = 3'h1;
  localparam logic [2:0] OFS_IRQ_STAT = 3'h2;
  localparam logic [2:0] OFS_LINE_CMP = 3'h3;
  localparam logic [2:0] OFS_BG_COLOR = 3'h4;
  localparam logic [2:0] OFS_SCROLL   = 3'h5;
  localparam logic [2:0] OFS_COMMIT   = 3'h6;
  localparam logic [2:0] OFS_FRAMECNT = 3'h7;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_VB_IE = 1;
  localparam int CTRL_LN_IE = 2;
  localparam int IRQ_VB     = 0;
  localparam int IRQ_LN     = 1;

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} commit_st_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] dat,
                                             input logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? dat[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/vga_cfg_ctrl_if.sv
// Wishbone slave port bundle for the VGA config controller.
interface vga_cfg_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/vga_cfg_irq.sv
// Vblank/line-match event latch (W1C, set beats clear) and registered, enable-masked irq.
module vga_cfg_irq
  import vga_cfg_pkg::*;
#(
  parameter int LINE_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank_i,
  input  logic              line_start_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic [LINE_W-1:0] line_cmp,
  input  logic [1:0]        w1c,
  input  logic [1:0]        irq_en,
  output logic [1:0]        irq_stat,
  output logic              irq_o
);
  logic       vb_q;
  logic [1:0] set;

  assign set[IRQ_VB] = vblank_i & ~vb_q;
  assign set[IRQ_LN] = line_start_i & (line_i == line_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_q     <= 1'b0;
      irq_stat <= '0;
      irq_o    <= 1'b0;
    end else begin
      vb_q     <= vblank_i;
      irq_stat <= (irq_stat & ~w1c) | set;
      irq_o    <= |(irq_stat & irq_en);
    end
  end
endmodule

// File: rtl/vga_cfg_ctrl.sv
// Wishbone config/sequencing controller: shadowed frame settings committed at frame start, irqs.
// Optional VGA_CFG_FRAMECNT_EN adds a read-only 16-bit frame counter at offset 0x1C.
module vga_cfg_ctrl
  import vga_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          LINE_W    = 11,
  parameter int          COLOR_W   = 12,
  parameter int          SCROLL_W  = 10
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  vga_cfg_ctrl_if.slave       wb,
  input  logic                frame_start_i,
  input  logic                line_start_i,
  input  logic [LINE_W-1:0]   line_i,
  input  logic                vblank_i,
  output logic                cfg_enable_o,
  output logic [COLOR_W-1:0]  cfg_bg_color_o,
  output logic [SCROLL_W-1:0] cfg_scroll_x_o,
  output logic [SCROLL_W-1:0] cfg_scroll_y_o,
  output logic                irq_o
);
  logic                hit, ack_q, wr, commit_wr, apply;
  logic [2:0]          ofs;
  logic [31:0]         rdata, wval, dat_q;
  logic [2:0]          ctrl_q;
  logic [LINE_W-1:0]   line_cmp_q;
  logic [COLOR_W-1:0]  bg_sh_q;
  logic [SCROLL_W-1:0] sx_sh_q, sy_sh_q;
  logic [1:0]          irq_stat, w1c;
  logic [15:0]         frame_cnt;
  commit_st_e          state_q, state_d;
  logic                unused;

  assign hit       = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign ofs       = wb.wbs_adr_i[4:2];
  assign wr        = hit & ack_q & wb.wbs_we_i;
  // Byte-masked write value built from the current readback of the addressed register.
  assign wval      = byte_merge(rdata, wb.wbs_dat_i, wb.wbs_sel_i);
  assign commit_wr = wr & (ofs == OFS_COMMIT) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
  assign w1c       = (wr && ofs == OFS_IRQ_STAT && wb.wbs_sel_i[0]) ? wb.wbs_dat_i[1:0] : 2'b00;
  assign unused    = ^{wb.wbs_adr_i[1:0], wval};

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_CTRL:     rdata[2:0] = ctrl_q;
      OFS_STATUS: begin
        rdata[0]             = vblank_i;
        rdata[1]             = (state_q == PENDING);
        rdata[16 +: LINE_W]  = line_i;
      end
      OFS_IRQ_STAT: rdata[1:0] = irq_stat;
      OFS_LINE_CMP: rdata[LINE_W-1:0] = line_cmp_q;
      OFS_BG_COLOR: rdata[COLOR_W-1:0] = bg_sh_q;
      OFS_SCROLL: begin
        rdata[SCROLL_W-1:0]    = sx_sh_q;
        rdata[16 +: SCROLL_W]  = sy_sh_q;
      end
      OFS_FRAMECNT: rdata[15:0] = frame_cnt;
      default:      rdata = '0;
    endcase
  end

  // A commit landing on the applying frame_start re-arms for the next frame.
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    case (state_q)
      IDLE:    if (commit_wr) state_d = PENDING;
      PENDING: if (frame_start_i) begin
        apply   = 1'b1;
        state_d = commit_wr ? PENDING : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q        <= IDLE;
      ack_q          <= 1'b0;
      dat_q          <= '0;
      ctrl_q         <= '0;
      line_cmp_q     <= '0;
      bg_sh_q        <= '0;
      sx_sh_q        <= '0;
      sy_sh_q        <= '0;
      cfg_bg_color_o <= '0;
      cfg_scroll_x_o <= '0;
      cfg_scroll_y_o <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= hit & ~ack_q;
      dat_q   <= (hit & ~ack_q & ~wb.wbs_we_i) ? rdata : '0;
      if (wr) begin
        case (ofs)
          OFS_CTRL:     ctrl_q     <= wval[2:0];
          OFS_LINE_CMP: line_cmp_q <= wval[LINE_W-1:0];
          OFS_BG_COLOR: bg_sh_q    <= wval[COLOR_W-1:0];
          OFS_SCROLL: begin
            sx_sh_q <= wval[SCROLL_W-1:0];
            sy_sh_q <= wval[16 +: SCROLL_W];
          end
          default: ;
        endcase
      end
      if (apply) begin
        cfg_bg_color_o <= bg_sh_q;
        cfg_scroll_x_o <= sx_sh_q;
        cfg_scroll_y_o <= sy_sh_q;
      end
    end
  end

`ifdef VGA_CFG_FRAMECNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)        frame_cnt_q <= '0;
    else if (frame_start_i) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign cfg_enable_o = ctrl_q[CTRL_EN];

  vga_cfg_irq #(.LINE_W(LINE_W)) u_irq (
    .clk          (wb_clk_i),
    .rst_n        (wb_rst_n_i),
    .vblank_i     (vblank_i),
    .line_start_i (line_start_i),
    .line_i       (line_i),
    .line_cmp     (line_cmp_q),
    .w1c          (w1c),
    .irq_en       (ctrl_q[CTRL_LN_IE:CTRL_VB_IE]),
    .irq_stat     (irq_stat),
    .irq_o        (irq_o)
  );
endmodule

// File: tb/tb_vga_cfg_ctrl.sv
// Randomized bench for vga_cfg_ctrl against a register-level reference model.
module tb_vga_cfg_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0, line_start = 1'b0, vblank = 1'b0;
  logic [10:0] line = '0;
  logic        cfg_en, irq;
  logic [11:0] cfg_bg;
  logic [9:0]  cfg_sx, cfg_sy;

  int n_chk = 0, n_err = 0;

  // reference model state
  logic [2:0]  m_ctrl;
  logic [10:0] m_lcmp, m_line;
  logic [11:0] m_bg, a_bg;
  logic [9:0]  m_sx, m_sy, a_sx, a_sy;
  logic [1:0]  m_stat;
  logic        m_pend, m_vb;
  logic [15:0] m_fcnt;

  vga_cfg_ctrl_if bus();

  vga_cfg_ctrl dut (
    .wb_clk_i       (clk),
    .wb_rst_n_i     (rst_n),
    .wb             (bus),
    .frame_start_i  (frame_start),
    .line_start_i   (line_start),
    .line_i         (line),
    .vblank_i       (vblank),
    .cfg_enable_o   (cfg_en),
    .cfg_bg_color_o (cfg_bg),
    .cfg_scroll_x_o (cfg_sx),
    .cfg_scroll_y_o (cfg_sy),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_lcmp = '0; m_bg = '0; a_bg = '0; m_sx = '0; m_sy = '0;
    a_sx = '0; a_sy = '0; m_stat = '0; m_pend = 1'b0; m_fcnt = '0;
  endtask

  function automatic logic [31:0] exp_read(input int ofs);
    logic [31:0] r = '0;
    case (ofs)
      0: r[2:0] = m_ctrl;
      1: begin r[0] = m_vb; r[1] = m_pend; r[26:16] = m_line; end
      2: r[1:0] = m_stat;
      3: r[10:0] = m_lcmp;
      4: r[11:0] = m_bg;
      5: begin r[9:0] = m_sx; r[25:16] = m_sy; end
`ifdef VGA_CFG_FRAMECNT_EN
      7: r[15:0] = m_fcnt;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_frame();
    if (m_pend) begin a_bg = m_bg; a_sx = m_sx; a_sy = m_sy; m_pend = 1'b0; end
    m_fcnt = m_fcnt + 16'd1;
  endtask

  task automatic model_write(input int ofs, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] m = merge(exp_read(ofs), d, sel);
    case (ofs)
      0: m_ctrl = m[2:0];
      2: if (sel[0]) m_stat = m_stat & ~d[1:0];
      3: m_lcmp = m[10:0];
      4: m_bg = m[11:0];
      5: begin m_sx = m[9:0]; m_sy = m[25:16]; end
      6: if (sel[0] && d[0]) m_pend = 1'b1;
      default: ;
    endcase
  endtask

  // One Wishbone access; fs/ls pulse on the ack cycle, where a write lands.
  task automatic wb_acc(input bit we, input logic [31:0] adr, input logic [31:0] d,
                        input logic [3:0] sel, input bit fs, input bit ls,
                        output logic [31:0] rd);
    int k = 0;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = d; bus.wbs_sel_i = sel;
    @(negedge clk);
    while (bus.wbs_ack_o !== 1'b1 && k < 4) begin @(negedge clk); k++; end
    chk("ack_latency", k, 0);
    rd = bus.wbs_dat_o;
    frame_start = fs; line_start = ls;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    frame_start = 1'b0; line_start = 1'b0;
  endtask

  task automatic wr(input int ofs, input logic [31:0] d, input logic [3:0] sel,
                    input bit fs, input bit ls);
    logic [31:0] rd;
    wb_acc(1'b1, BASE + ofs * 4, d, sel, fs, ls, rd);
    if (fs) model_frame();
    model_write(ofs, d, sel);
    if (ls && m_line == m_lcmp) m_stat[1] = 1'b1;
  endtask

  task automatic rd_chk(input int ofs);
    logic [31:0] rd;
    wb_acc(1'b0, BASE + ofs * 4, 32'h0, 4'hF, 1'b0, 1'b0, rd);
    chk($sformatf("read_%02h", ofs * 4), rd, exp_read(ofs));
  endtask

  task automatic pulse_fs();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    model_frame();
  endtask

  task automatic pulse_ls(input logic [10:0] l);
    @(negedge clk); line = l; line_start = 1'b1;
    @(negedge clk); line_start = 1'b0;
    m_line = l;
    if (l == m_lcmp) m_stat[1] = 1'b1;
  endtask

  task automatic set_vb(input logic v);
    @(negedge clk); vblank = v;
    if (v && !m_vb) m_stat[0] = 1'b1;
    m_vb = v;
    @(negedge clk);
  endtask

  task automatic chk_out();
    @(negedge clk);
    chk("cfg_enable", cfg_en, m_ctrl[0]);
    chk("cfg_bg", cfg_bg, a_bg);
    chk("cfg_sx", cfg_sx, a_sx);
    chk("cfg_sy", cfg_sy, a_sy);
    chk("irq", irq, |(m_stat & m_ctrl[2:1]));
  endtask

  initial begin
    int acks, bad;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    model_reset(); m_vb = 1'b0; m_line = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {cfg_en, cfg_bg, cfg_sx, cfg_sy, irq, bus.wbs_ack_o}, 0);
    rst_n = 1'b1;
    chk_out();
    for (int o = 0; o < 8; o++) rd_chk(o);

    // commit sequencing
    wr(4, 32'hABC, 4'hF, 0, 0);
    wr(5, 32'h0005_0012, 4'hF, 0, 0);
    wr(6, 32'h1, 4'hF, 0, 0);
    rd_chk(1);
    chk_out();
    pulse_fs();
    chk("bg_after_fs", cfg_bg, 12'hABC);
    chk("sx_after_fs", cfg_sx, 10'h012);
    chk("sy_after_fs", cfg_sy, 10'h005);
    rd_chk(1);

    // commit coincident with frame_start from IDLE defers a frame
    wr(4, 32'h123, 4'hF, 0, 0);
    wr(6, 32'h1, 4'hF, 1, 0);
    chk_out();
    rd_chk(1);
    pulse_fs();
    chk_out();

    // commit coincident with applying frame_start re-arms
    wr(4, 32'h456, 4'hF, 0, 0);
    wr(6, 32'h1, 4'hF, 0, 0);
    wr(4, 32'h789, 4'hF, 0, 0);
    wr(6, 32'h1, 4'hF, 1, 0);
    chk_out();
    rd_chk(1);

    // line-compare irq, W1C, set beats clear
    wr(3, 32'd100, 4'hF, 0, 0);
    wr(0, 32'h5, 4'hF, 0, 0);
    pulse_ls(11'd100);
    rd_chk(2);
    chk_out();
    wr(2, 32'h2, 4'hF, 0, 0);
    chk_out();
    pulse_ls(11'd100);
    wr(2, 32'h2, 4'hF, 0, 1);
    rd_chk(2);
    chk_out();

    // byte select and decode miss
    wr(5, 32'h0, 4'hF, 0, 0);
    wr(5, 32'hFFFF_FFFF, 4'b0001, 0, 0);
    rd_chk(5);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE + 32'h40;
    acks = 0; bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.wbs_ack_o) acks++;
      if (bus.wbs_dat_o != 0) bad++;
    end
    chk("miss_ack", acks, 0);
    chk("miss_dat", bad, 0);
    // held strobe acks every second cycle
    bus.wbs_adr_i = BASE;
    acks = 0;
    repeat (6) begin @(negedge clk); if (bus.wbs_ack_o) acks++; end
    chk("held_stb_acks", acks, 3);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    rd_chk(7);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int op = $urandom_range(0, 5);
      int o  = $urandom_range(0, 7);
      logic [31:0] d = $urandom;
      logic [3:0] s = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
      case (op)
        0, 1: begin
          if (o == 6) d[0] = $urandom_range(0, 3) != 0;
          wr(o, d, s, $urandom_range(0, 5) == 0, 0);
        end
        2: rd_chk(o);
        3: pulse_fs();
        4: pulse_ls($urandom_range(0, 1) ? m_lcmp : 11'($urandom));
        default: set_vb(1'($urandom));
      endcase
      chk_out();
    end
    for (int o = 0; o < 8; o++) rd_chk(o);

    // asynchronous reset mid-operation
    wr(4, 32'hFFF, 4'hF, 0, 0);
    wr(6, 32'h1, 4'hF, 0, 0);
    wr(0, 32'h7, 4'hF, 0, 0);
    pulse_ls(m_lcmp);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("async_rst_out", {cfg_en, cfg_bg, cfg_sx, cfg_sy, irq}, 0);
    model_reset();
    @(negedge clk); vblank = 1'b0; m_vb = 1'b0; rst_n = 1'b1;
    rd_chk(1);
    rd_chk(2);
    chk_out();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
